// File: rtl/axis_header_insert_strip.sv
// rtl/axis_header_insert_strip.sv - per-packet AXI-Stream header insert / strip / bypass with realignment
module axis_header_insert_strip #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  input  logic                       valid_hdr,
  input  logic [DATA_WIDTH-1:0]      data_hdr,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_hdr,
  input  logic [BYTE_CNT_WIDTH-1:0]  hdr_cnt,
  input  logic [1:0]                 hdr_mode,
  output logic                       ready_hdr
);

  // Byte counts span 0..2*DATA_BYTE_WIDTH (residual plus one incoming beat).
  localparam int CW = BYTE_CNT_WIDTH + 2;
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTE_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [1:0]            mode_q;
  logic [CW-1:0]         n_q;
  logic                  first_q;
  logic [DATA_WIDTH-1:0] res_data;
  logic [CW-1:0]         res_cnt;

  logic                    hdr_fire, in_fire, out_free;
  logic [CW-1:0]           in_k, strip_n, m_cnt, total, hdr_shift;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [2*DATA_WIDTH-1:0] combined;
  logic                    ld, ld_last, res_we;
  logic [DATA_WIDTH-1:0]   ld_data, res_d;
  logic [CW-1:0]           ld_cnt, res_cnt_d;

  // The header keep is informational only; the byte count comes from hdr_cnt.
  logic unused_keep_hdr;
  assign unused_keep_hdr = ^keep_hdr;

  function automatic logic [DATA_BYTE_WIDTH-1:0] keep_of(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WIDTH-1:0] ones;
    ones = '1;
    return ~(ones >> cnt);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [DATA_BYTE_WIDTH-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WIDTH; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Merge the MSB-aligned residual with the (optionally stripped) incoming bytes.
  always_comb begin
    in_k = '0;
    for (int i = 0; i < DATA_BYTE_WIDTH; i++) in_k = in_k + {{(CW-1){1'b0}}, keep_in[i]};
    strip_n   = (mode_q == 2'b01 && first_q) ? n_q : '0;
    m_cnt     = (in_k > strip_n) ? in_k - strip_n : '0;
    shifted   = (data_in & byte_mask(keep_in)) << {strip_n, 3'b000};
    combined  = {res_data, {DATA_WIDTH{1'b0}}} | ({shifted, {DATA_WIDTH{1'b0}}} >> {res_cnt, 3'b000});
    total     = res_cnt + m_cnt;
    hdr_shift = FULL - CW'(hdr_cnt) - CW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_fire) state_nxt = RUN;
      RUN:     if (in_fire && last_in) state_nxt = (total > FULL) ? FLUSH : IDLE;
      FLUSH:   if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshakes, output-beat load and residual update per state.
  always_comb begin
    out_free  = !valid_out || ready_out;
    ready_in  = 1'b0;
    ready_hdr = 1'b0;
    ld        = 1'b0;
    ld_last   = 1'b0;
    ld_data   = combined[2*DATA_WIDTH-1 -: DATA_WIDTH];
    ld_cnt    = FULL;
    res_we    = 1'b0;
    res_d     = res_data;
    res_cnt_d = res_cnt;
    case (state)
      IDLE: ready_hdr = rst_n;
      RUN: begin
        ready_in = rst_n && out_free;
        if (valid_in && ready_in) begin
          res_we = 1'b1;
          if (last_in && total <= FULL) begin
            ld        = (total != '0);
            ld_last   = 1'b1;
            ld_cnt    = total;
            res_d     = '0;
            res_cnt_d = '0;
          end else if (total >= FULL) begin
            ld        = 1'b1;
            res_d     = combined[DATA_WIDTH-1:0];
            res_cnt_d = total - FULL;
          end else begin
            res_d     = combined[2*DATA_WIDTH-1 -: DATA_WIDTH];
            res_cnt_d = total;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ld        = 1'b1;
          ld_last   = 1'b1;
          ld_data   = res_data;
          ld_cnt    = res_cnt;
          res_we    = 1'b1;
          res_d     = '0;
          res_cnt_d = '0;
        end
      end
      default: ;
    endcase
    hdr_fire = valid_hdr && ready_hdr;
    in_fire  = valid_in && ready_in;
  end

  // Command latch, residual register and single-stage output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= '0;
      n_q       <= '0;
      first_q   <= 1'b0;
      res_data  <= '0;
      res_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (hdr_fire) begin
        mode_q   <= hdr_mode;
        n_q      <= CW'(hdr_cnt) + CW'(1);
        first_q  <= 1'b1;
        res_data <= (hdr_mode == 2'b00) ? data_hdr << {hdr_shift, 3'b000} : '0;
        res_cnt  <= (hdr_mode == 2'b00) ? CW'(hdr_cnt) + CW'(1) : '0;
      end else if (res_we) begin
        res_data <= res_d;
        res_cnt  <= res_cnt_d;
      end
      if (in_fire) first_q <= 1'b0;
      if (out_free) begin
        valid_out <= ld;
        data_out  <= ld ? (ld_data & byte_mask(keep_of(ld_cnt))) : '0;
        keep_out  <= ld ? keep_of(ld_cnt) : '0;
        last_out  <= ld && ld_last;
      end
    end
  end

endmodule

// File: tb/tb_axis_header_insert_strip.sv
// tb/tb_axis_header_insert_strip.sv - self-checking bench for axis_header_insert_strip
module tb_axis_header_insert_strip;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_hdr = 1'b0;
  logic [31:0] data_hdr = '0;
  logic [3:0]  keep_hdr = '0;
  logic [1:0]  hdr_cnt = '0;
  logic [1:0]  hdr_mode = '0;
  logic        ready_hdr;

  axis_header_insert_strip #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .hdr_cnt(hdr_cnt), .hdr_mode(hdr_mode),
    .ready_hdr(ready_hdr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  logic [36:0] got[$];
  logic [36:0] exp_q[$];
  logic [36:0] hold_v;
  bit stalled = 1'b0;

  typedef struct {
    logic [1:0]       mode;
    logic [1:0]       cnt;
    logic [31:0]      hdr;
    int               nin;
    logic [3:0][31:0] din;
    logic [3:0]       klast;
    int               nout;
    logic [2:0][31:0] dout;
    logic [2:0][3:0]  kout;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [1:0] mode, input logic [1:0] cnt, input logic [31:0] hdr,
                              input int nin, input logic [3:0][31:0] din, input logic [3:0] klast,
                              input int nout, input logic [2:0][31:0] dout, input logic [2:0][3:0] kout);
    vec_t v;
    v.mode = mode; v.cnt = cnt; v.hdr = hdr; v.nin = nin; v.din = din; v.klast = klast;
    v.nout = nout; v.dout = dout; v.kout = kout;
    return v;
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Output monitor: collects accepted beats, checks stall stability and full non-last beats.
  always @(negedge clk) begin
    if (stalled) begin
      checks++;
      if (!valid_out || {last_out, keep_out, data_out} != hold_v) begin
        errors++;
        $display("FAIL hold: got v=%0b %h want v=1 %h", valid_out, {last_out, keep_out, data_out}, hold_v);
      end
    end
    if (rst_n && valid_out && ready_out) begin
      got.push_back({last_out, keep_out, data_out});
      if (!last_out) begin
        checks++;
        if (keep_out != 4'hF) begin
          errors++;
          $display("FAIL nonlast_keep: got %h want f", keep_out);
        end
      end
    end
    stalled = rst_n && valid_out && !ready_out;
    hold_v  = {last_out, keep_out, data_out};
  end

  // Downstream ready: always 1 in directed tests, 50% random otherwise.
  initial forever begin
    @(posedge clk);
    #1;
    ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d want finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [1:0] mode, input logic [1:0] cnt, input logic [31:0] hdr);
    bit fire;
    int guard;
    if (rand_ready) repeat ($urandom_range(0, 2)) tick();
    hdr_mode = mode; hdr_cnt = cnt; data_hdr = hdr;
    keep_hdr = 4'((32'd1 << (int'(cnt) + 1)) - 1);
    valid_hdr = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      fire = ready_hdr;
      tick();
      guard++;
    end while (!fire && guard < 500);
    valid_hdr = 1'b0;
    if (!fire) begin
      checks++; errors++;
      $display("FAIL hdr_timeout: got ready_hdr=0 want 1");
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit fire;
    int guard;
    data_in = d; keep_in = k; last_in = l; valid_in = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      fire = ready_in;
      tick();
      guard++;
    end while (!fire && guard < 500);
    valid_in = 1'b0;
    if (!fire) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got ready_in=0 want 1");
    end
  endtask

  task automatic send_packet(input logic [1:0] mode, input logic [1:0] cnt, input logic [31:0] hdr,
                             input int nb, input logic [3:0][31:0] d, input logic [3:0] klast);
    send_hdr(mode, cnt, hdr);
    for (int i = 0; i < nb; i++) begin
      if (rand_ready) while ($urandom_range(0, 1) == 1) tick();
      send_beat(d[i], (i == nb - 1) ? klast : 4'hF, i == nb - 1);
    end
  endtask

  // Byte-level reference: build the output byte stream, then cut it into beats.
  task automatic model(input logic [1:0] mode, input logic [1:0] cnt, input logic [31:0] hdr,
                       input int nb, input logic [3:0][31:0] d, input logic [3:0] klast);
    logic [7:0] b[$];
    logic [31:0] w;
    logic [3:0] kk;
    int n, kc, c;
    n = int'(cnt) + 1;
    if (mode == 2'b00) for (int j = 0; j < n; j++) b.push_back(hdr[8*(n-1-j) +: 8]);
    for (int i = 0; i < nb; i++) begin
      kc = (i == nb - 1) ? int'(klast[3]) + int'(klast[2]) + int'(klast[1]) + int'(klast[0]) : 4;
      w = d[i];
      for (int j = 0; j < kc; j++) b.push_back(w[31-8*j -: 8]);
    end
    if (mode == 2'b01) repeat (n) if (b.size() > 0) void'(b.pop_front());
    while (b.size() > 0) begin
      c = (b.size() >= 4) ? 4 : b.size();
      w = '0;
      for (int j = 0; j < c; j++) w[31-8*j -: 8] = b.pop_front();
      kk = ~(4'hF >> c);
      exp_q.push_back({b.size() == 0, kk, w});
    end
  endtask

  task automatic check_got(input int id, input int nout, input logic [2:0][31:0] dout, input logic [2:0][3:0] kout);
    logic [36:0] want;
    checks++;
    if (got.size() != nout) begin
      errors++;
      $display("FAIL vec%0d beat_count: got %0d want %0d", id, got.size(), nout);
    end
    for (int i = 0; i < nout && i < got.size(); i++) begin
      want = {i == nout - 1, kout[i], dout[i]};
      checks++;
      if (got[i] != want) begin
        errors++;
        $display("FAIL vec%0d beat%0d: got %h want %h", id, i, got[i], want);
      end
    end
    got.delete();
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [3:0] klast, ksel[4];
    logic [1:0] mode, cnt;
    logic [31:0] hdr;
    int nb, guard;
    bit ok;

    vecs[0] = mk(2'b00, 2'd1, 32'hDEADBEEF, 2, {32'h0, 32'h0, 32'h55667788, 32'h11223344}, 4'hF,
                 3, {32'h77880000, 32'h33445566, 32'hBEEF1122}, {4'hC, 4'hF, 4'hF});
    vecs[1] = mk(2'b00, 2'd3, 32'hDEADBEEF, 1, {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}, 4'h8,
                 2, {32'h0, 32'hAA000000, 32'hDEADBEEF}, {4'h0, 4'h8, 4'hF});
    vecs[2] = mk(2'b01, 2'd0, 32'h0, 2, {32'h0, 32'h0, 32'h55667788, 32'h11223344}, 4'hE,
                 2, {32'h0, 32'h66770000, 32'h22334455}, {4'h0, 4'hC, 4'hF});
    vecs[3] = mk(2'b10, 2'd0, 32'h0, 2, {32'h0, 32'h0, 32'h05060000, 32'h01020304}, 4'hC,
                 2, {32'h0, 32'h05060000, 32'h01020304}, {4'h0, 4'hC, 4'hF});
    vecs[4] = mk(2'b01, 2'd2, 32'h0, 2, {32'h0, 32'h0, 32'h55667788, 32'h11223344}, 4'hF,
                 2, {32'h0, 32'h88000000, 32'h44556677}, {4'h0, 4'h8, 4'hF});
    vecs[5] = mk(2'b00, 2'd0, 32'h123456AB, 1, {32'h0, 32'h0, 32'h0, 32'h11220000}, 4'hC,
                 1, {32'h0, 32'h0, 32'hAB112200}, {4'h0, 4'h0, 4'hE});

    // Reset state
    repeat (3) tick();
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_hdr} != 39'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", {valid_out, data_out, keep_out, last_out, ready_in, ready_hdr});
    end
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      send_packet(vecs[v].mode, vecs[v].cnt, vecs[v].hdr, vecs[v].nin, vecs[v].din, vecs[v].klast);
      repeat (6) tick();
      check_got(v, vecs[v].nout, vecs[v].dout, vecs[v].kout);
    end

    // Strip consumes the whole packet; header channel reopens quickly, then bypass
    d = '0; d[0] = 32'h01020304;
    send_packet(2'b01, 2'd3, 32'h0, 1, d, 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(negedge clk);
      ok = ready_hdr;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL strip_all_ready_hdr: got 0 want 1 within 2 cycles");
    end
    tick();
    d[0] = 32'hCAFEF00D;
    send_packet(2'b10, 2'd0, 32'h0, 1, d, 4'hF);
    repeat (6) tick();
    check_got(6, 1, {32'h0, 32'h0, 32'hCAFEF00D}, {4'h0, 4'h0, 4'hF});

    // Reset mid-packet with a residual held
    send_hdr(2'b00, 2'd1, 32'hDEADBEEF);
    send_beat(32'h11223344, 4'hF, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_hdr} != 39'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0", {valid_out, data_out, keep_out, last_out, ready_in, ready_hdr});
    end
    rst_n = 1'b1;
    got.delete();
    @(negedge clk);
    checks++;
    if (ready_hdr !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle: got ready_hdr=%b want 1", ready_hdr);
    end
    tick();
    d[0] = 32'h11223344;
    send_packet(2'b00, 2'd0, 32'h000000AB, 1, d, 4'hF);
    repeat (6) tick();
    check_got(7, 2, {32'h0, 32'h44000000, 32'hAB112233}, {4'h0, 4'h8, 4'hF});

    // Random traffic against the byte-level model
    rand_ready = 1'b1;
    ksel[0] = 4'h8; ksel[1] = 4'hC; ksel[2] = 4'hE; ksel[3] = 4'hF;
    for (int p = 0; p < 200; p++) begin
      mode  = 2'($urandom_range(0, 3));
      cnt   = 2'($urandom_range(0, 3));
      hdr   = $urandom;
      nb    = $urandom_range(1, 4);
      klast = ksel[$urandom_range(0, 3)];
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      d[nb-1] = d[nb-1] & kmask(klast);
      model(mode, cnt, hdr, nb, d, klast);
      send_packet(mode, cnt, hdr, nb, d, klast);
    end
    guard = 0;
    while (got.size() < exp_q.size() && guard < 2000) begin
      tick();
      guard++;
    end
    rand_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_beat_count: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] != exp_q[i]) begin
        errors++;
        $display("FAIL random_beat%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_header_insert_strip.md
Name: axis_header_insert_strip

Overview:
- Per-packet AXI-Stream header processor; successor to the single-mode header inserter.
- A command beat on the header channel selects one of three operations for the next packet: prepend 1..DATA_BYTE_WIDTH header bytes, strip 1..DATA_BYTE_WIDTH leading bytes, or pass the packet through unchanged.
- Output is realigned so every non-last beat is full.
- Sits between the packet source and the downstream AXI-Stream slave.

Parameters:
- DATA_WIDTH, 32, stream/header data width in bits; multiple of 8, at least 16.
- DATA_BYTE_WIDTH, DATA_WIDTH/8, bytes per beat (derived).
- BYTE_CNT_WIDTH, $clog2(DATA_BYTE_WIDTH), byte-count width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- valid_in  in  1  stream input valid.
- data_in  in  DATA_WIDTH  stream input data.
- keep_in  in  DATA_BYTE_WIDTH  byte enables. Non-last beats are all ones; the last beat is contiguous from the MSB, 1..DATA_BYTE_WIDTH bytes.
- last_in  in  1  final beat of packet.
- ready_in  out  1  stream input ready.
- valid_out  out  1  output valid.
- data_out  out  DATA_WIDTH  output data.
- keep_out  out  DATA_BYTE_WIDTH  output byte enables, same convention as keep_in.
- last_out  out  1  output final beat.
- ready_out  in  1  downstream ready.
- valid_hdr  in  1  command/header valid.
- data_hdr  in  DATA_WIDTH  header bytes; valid bytes are LSB-aligned.
- keep_hdr  in  DATA_BYTE_WIDTH  header enables, contiguous from the LSB (informational; hdr_cnt governs).
- hdr_cnt  in  BYTE_CNT_WIDTH  byte count minus 1 (n = hdr_cnt+1) for insert or strip.
- hdr_mode  in  2  00 insert, 01 strip, 10/11 bypass.
- ready_hdr  out  1  command ready.

Behaviour:
- Byte order: byte 0 (first on the wire) is data[DATA_WIDTH-1 -: 8]; keep[DATA_BYTE_WIDTH-1] qualifies byte 0.
- Reset: valid_out, data_out, keep_out, last_out, ready_in and ready_hdr are all 0. State is IDLE and the residual register is cleared. Reset mid-packet discards all buffered bytes; the bench re-drives from a packet boundary.
- State IDLE:
  - ready_hdr=1, ready_in=0.
  - A valid_hdr&&ready_hdr handshake latches mode, n and data_hdr, then moves to RUN. ready_hdr drops the next cycle.
- State RUN: ready_in = !valid_out || ready_out; the output register is a single stage with no combinational path from ready_out to valid_out.
- Insert mode:
  - The residual starts as the n header bytes, ordered from data_hdr byte n-1 down to byte 0.
  - Each output beat = residual (n bytes) followed by the first DATA_BYTE_WIDTH-n bytes of the input beat. The new residual = the last n bytes of the input beat.
  - When n==DATA_BYTE_WIDTH, the header is emitted as its own full beat and data passes through unshifted.
- Strip mode:
  - The first n bytes of the packet are discarded.
  - Output beats are realigned so the first surviving byte lands in byte 0.
  - n==DATA_BYTE_WIDTH drops the entire first beat.
- Bypass: beats are copied unchanged, including keep and last.
- Last input beat with k valid bytes:
  - Output total T = packet bytes + n (insert) or packet bytes − n (strip).
  - If the remaining residual + k bytes fit in one beat, emit one beat with last_out=1 and keep = that count, MSB-aligned. Otherwise emit a full beat, then enter FLUSH.
  - In strip mode with T≤0, no output beat is emitted for the packet.
  - Either way the block returns to IDLE once the final beat is loaded (or dropped).
- State FLUSH: ready_in=0. The residual is emitted as one beat with last_out=1 and keep = residual count. Moves to IDLE when that beat is loaded into the output register.
- Output hold: while valid_out && !ready_out, data_out, keep_out and last_out are held stable.
- Latency and throughput:
  - Output is valid one cycle after the input handshake that completes the beat.
  - Sustained throughput is one beat per cycle; FLUSH adds one cycle per packet.
  - There is a minimum one-cycle IDLE gap between packets.
- Invalid bytes of data_out (keep=0) are driven to 0.

Test Plan:
1. Insert, 32b: hdr_cnt=1, data_hdr=0xDEADBEEF; packet 0x11223344 (keep 1111), 0x55667788 (keep 1111, last), ready_out=1 -> outputs 0xBEEF1122/1111, 0x33445566/1111, 0x77880000/1100 last.
2. Insert, full header: hdr_cnt=3, data_hdr=0xDEADBEEF; one-beat packet 0xAABBCCDD keep 1000 last -> outputs 0xDEADBEEF/1111, then 0xAA000000/1000 last.
3. Strip: hdr_mode=01, hdr_cnt=0; packet 0x11223344/1111, 0x55667788/1110 last -> outputs 0x22334455/1111, 0x66770000/1100 last.
4. Strip, whole packet consumed: hdr_cnt=3; one-beat packet 0x01020304/1111 last -> no valid_out; ready_hdr=1 again within 2 cycles. The next bypass packet 0xCAFEF00D/1111 last emerges unchanged.
5. Random traffic: ready_out, valid_in and valid_hdr toggle randomly at 50%; 200 packets of mixed modes and random lengths/keeps -> the scoreboard byte stream matches exactly. No beat changes while valid_out&&!ready_out, and every non-last output beat has keep=1111.
6. Reset mid-packet: assert rst_n=0 during RUN with a residual held -> the next cycle all outputs are 0 and ready_hdr=0. After release, IDLE with ready_hdr=1; the following packet is unaffected by stale residual bytes.
